// File: rtl/vuvxu_issue_arb.sv
// Issue-port arbiter between the TVEC and VT issue units, with per-unit
// VLU/VSU outstanding-op tracking and TVEC fence draining.
module vuvxu_issue_arb #(
  parameter int PAYLOAD_W = 64,
  parameter int MAX_OUT   = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tvec_val,
  output logic                 tvec_rdy,
  input  logic [2:0]           tvec_fu,
  input  logic                 tvec_fence,
  input  logic [PAYLOAD_W-1:0] tvec_payload,
  input  logic                 vt_val,
  output logic                 vt_rdy,
  input  logic [2:0]           vt_fu,
  input  logic [PAYLOAD_W-1:0] vt_payload,
  output logic                 seq_val,
  input  logic                 seq_rdy,
  output logic [2:0]           seq_fu,
  output logic                 seq_src,
  output logic [PAYLOAD_W-1:0] seq_payload,
  input  logic                 vlu_done,
  input  logic                 vsu_done,
  output logic                 fence_done,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic {ST_ARB, ST_DRAIN} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vlu_cnt_q, vlu_cnt_d;
  logic [CNT_W-1:0] vsu_cnt_q, vsu_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             err_q, err_d;

  logic vlu_room, vsu_room;
  logic tvec_elig, vt_elig;
  logic in_arb, grant_tvec, grant_vt, fence_grant;
  logic issue, vlu_inc, vsu_inc, vlu_dec, vsu_dec, drained;

  always_comb begin
    vlu_room  = (vlu_cnt_q < MAX_C);
    vsu_room  = (vsu_cnt_q < MAX_C);
    tvec_elig = tvec_val && (tvec_fence ||
                ((!tvec_fu[1] || vlu_room) && (!tvec_fu[2] || vsu_room)));
    vt_elig   = vt_val && (!vt_fu[1] || vlu_room) && (!vt_fu[2] || vsu_room);

    // Reset suppresses every grant so nothing is accepted while tracking is cleared.
    in_arb      = !reset && (state_q == ST_ARB);
    grant_tvec  = in_arb && tvec_elig && (!vt_elig || last_grant_q);
    grant_vt    = in_arb && vt_elig && !grant_tvec;
    fence_grant = grant_tvec && tvec_fence;

    seq_val     = grant_vt || (grant_tvec && !tvec_fence);
    seq_src     = grant_vt;
    seq_fu      = '0;
    seq_payload = '0;
    if (grant_vt) begin
      seq_fu      = vt_fu;
      seq_payload = vt_payload;
    end else if (seq_val) begin
      seq_fu      = tvec_fu;
      seq_payload = tvec_payload;
    end

    tvec_rdy = fence_grant || (grant_tvec && !tvec_fence && seq_rdy);
    vt_rdy   = grant_vt && seq_rdy;
    issue    = seq_val && seq_rdy;

    last_grant_d = (tvec_rdy || vt_rdy) ? grant_vt : last_grant_q;

    // A done with nothing outstanding is dropped rather than wrapping the counter.
    vlu_inc   = issue && seq_fu[1];
    vsu_inc   = issue && seq_fu[2];
    vlu_dec   = vlu_done && (vlu_cnt_q != '0);
    vsu_dec   = vsu_done && (vsu_cnt_q != '0);
    vlu_cnt_d = vlu_cnt_q + CNT_W'(vlu_inc) - CNT_W'(vlu_dec);
    vsu_cnt_d = vsu_cnt_q + CNT_W'(vsu_inc) - CNT_W'(vsu_dec);
    err_d     = err_q || (vlu_done && !vlu_dec) || (vsu_done && !vsu_dec);

    drained    = (vlu_cnt_q == '0) && (vsu_cnt_q == '0);
    fence_done = 1'b0;
    state_d    = state_q;
    case (state_q)
      ST_ARB: begin
        if (fence_grant) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d    = ST_ARB;
          fence_done = !reset;
        end
      end
      default: state_d = ST_ARB;
    endcase

    busy = !drained || (state_q == ST_DRAIN);
    err  = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARB;
      vlu_cnt_q    <= '0;
      vsu_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vlu_cnt_q    <= vlu_cnt_d;
      vsu_cnt_q    <= vsu_cnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule
